// File: rtl/masked_sbox_sequencer_if.sv
// Handshake bundle around the masked S-box sequencer: round-datapath input,
// core drive/sample, fresh-randomness request and result output.
interface masked_sbox_sequencer_if #(
   parameter int SHARES = 5,
   parameter int WIDTH  = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic [SHARES*WIDTH-1:0]   in_shares;
   logic [SHARES*WIDTH-1:0]   core_in;
   logic                      core_en;
   logic [SHARES*WIDTH-1:0]   core_out;
   logic                      rnd_valid;
   logic                      rnd_req;
   logic                      out_valid;
   logic                      out_ready;
   logic [SHARES*WIDTH-1:0]   out_shares;
   logic                      Synch;
   logic                      busy;

   // The sequencer itself.
   modport slave (
      input  in_valid, in_shares, core_out, rnd_valid, out_ready,
      output in_ready, core_in, core_en, rnd_req, out_valid, out_shares, Synch, busy
   );

   // The surrounding datapath, randomness source and core.
   modport master (
      output in_valid, in_shares, core_out, rnd_valid, out_ready,
      input  in_ready, core_in, core_en, rnd_req, out_valid, out_shares, Synch, busy
   );
endinterface

// File: rtl/masked_sbox_sequencer.sv
// Control and buffering shell for a register-stage masked S-box core.
// Iterative mode keeps one operation in flight (IDLE -> RUN -> CAP); pipelined
// mode tracks occupancy with a valid shift register and accepts one per cycle.
// The core only advances on cycles where fresh randomness is available and the
// result can go somewhere; shares are only ever moved, never recombined.
module masked_sbox_sequencer #(
   parameter int SHARES    = 5,
   parameter int WIDTH     = 4,
   parameter int LATENCY   = 10,
   parameter int PIPELINED = 0
) (
   input  logic                  clk,
   input  logic                  rst,
   masked_sbox_sequencer_if.slave bus
);

   localparam int W     = SHARES * WIDTH;
   localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_CAP
   } state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [LATENCY:0] r_v;          // r_v[0] tracks core_in, r_v[k] tracks core stage k-1
   logic             r_armed;      // low during reset and for the first edge after it
   logic [W-1:0]     r_core_in;
   logic [W-1:0]     r_out_shares;
   logic             r_out_valid;
   logic             r_synch;

   logic             w_in_ready;
   logic             w_core_en;
   logic             w_load;
   logic             w_stall;
   logic             w_accept;
   logic             w_cnt_last;

   // Arm the block one edge after reset so no combinational output is high in reset.
   always_ff @(posedge clk or negedge rst) begin
      // NOTE: every register uses <= so all flops sample pre-edge values together.
      if (!rst) r_armed <= 1'b0;
      else      r_armed <= 1'b1;
   end

   // Next-state, handshake and core-enable decode for both modes.
   always_comb begin
      // NOTE: defaults first so no path leaves a signal unassigned (no latches).
      w_state_nxt = r_state;
      w_in_ready  = 1'b0;
      w_core_en   = 1'b0;
      w_load      = 1'b0;
      w_stall     = 1'b1;
      w_cnt_last  = (r_cnt == CNT_W'(LATENCY - 1));

      if (PIPELINED != 0) begin
         // The pipe only freezes when its head cannot be unloaded or randomness is missing.
         w_stall    = (r_out_valid && !bus.out_ready && r_v[LATENCY]) || !bus.rnd_valid;
         w_in_ready = r_armed && !w_stall;
         w_core_en  = r_armed && !w_stall;
         w_load     = w_core_en && r_v[LATENCY];
      end else begin
         unique case (r_state)
            S_IDLE: begin
               w_in_ready = r_armed;
               if (r_armed && bus.in_valid) w_state_nxt = S_RUN;
            end
            S_RUN: begin
               w_core_en = bus.rnd_valid;
               if (bus.rnd_valid && w_cnt_last) w_state_nxt = S_CAP;
            end
            S_CAP: begin
               // Core stays frozen here until the output register can take the result.
               if (!r_out_valid || bus.out_ready) begin
                  w_load      = 1'b1;
                  w_state_nxt = S_IDLE;
               end
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end

      w_accept = bus.in_valid && w_in_ready;
   end

   // Iterative FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= S_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Count enabled core edges during RUN.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                               r_cnt <= '0;
      else if (w_accept)                      r_cnt <= '0;
      else if (r_state == S_RUN && w_core_en) r_cnt <= r_cnt + CNT_W'(1);
   end

   // Pipelined occupancy: shifts in lock-step with the core registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             r_v <= '0;
      else if (PIPELINED != 0 && w_core_en) r_v <= {r_v[LATENCY-1:0], w_accept};
   end

   // Input share register presented to the core; held between accepts.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)          r_core_in <= '0;
      else if (w_accept) r_core_in <= bus.in_shares;
   end

   // Output register: a load wins over a drain on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_out_shares <= '0;
         r_out_valid  <= 1'b0;
      end else if (w_load) begin
         r_out_shares <= bus.core_out;
         r_out_valid  <= 1'b1;
      end else if (bus.out_ready) begin
         r_out_valid  <= 1'b0;
      end
   end

   // Synch marks the first cycle each new result is visible.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_synch <= 1'b0;
      else      r_synch <= w_load;
   end

   assign bus.in_ready   = w_in_ready;
   assign bus.core_in    = r_core_in;
   assign bus.core_en    = w_core_en;
   assign bus.rnd_req    = w_core_en;
   assign bus.out_valid  = r_out_valid;
   assign bus.out_shares = r_out_shares;
   assign bus.Synch      = r_synch;
   assign bus.busy       = (r_state != S_IDLE) || (|r_v) || r_out_valid;

endmodule

// File: tb/tb_masked_sbox_sequencer.sv
// Bench for masked_sbox_sequencer: one iterative and one pipelined instance,
// each driving a reference core (enabled shift register applying the Skinny
// S-box to the share-XOR). Results are checked by a scoreboard monitor.
module tb_masked_sbox_sequencer;

   localparam int SHARES = 5;
   localparam int WIDTH  = 4;
   localparam int LAT    = 10;
   localparam int W      = SHARES * WIDTH;

   localparam logic [3:0] SBOX_TAB [16] = '{
      4'hC, 4'h6, 4'h9, 4'h0, 4'h1, 4'hA, 4'h2, 4'hB,
      4'h3, 4'h8, 4'h5, 4'hD, 4'h4, 4'hE, 4'h7, 4'hF
   };

   logic clk = 1'b0;
   logic rst;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   logic [W-1:0] it_q [$];
   logic [W-1:0] pp_q [$];
   int           pp_log [$];
   int           it_synch_n = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   masked_sbox_sequencer_if #(.SHARES(SHARES), .WIDTH(WIDTH)) it_if ();
   masked_sbox_sequencer_if #(.SHARES(SHARES), .WIDTH(WIDTH)) pp_if ();

   masked_sbox_sequencer #(.SHARES(SHARES), .WIDTH(WIDTH), .LATENCY(LAT), .PIPELINED(0)) dut_it (
      .clk (clk),
      .rst (rst),
      .bus (it_if)
   );

   masked_sbox_sequencer #(.SHARES(SHARES), .WIDTH(WIDTH), .LATENCY(LAT), .PIPELINED(1)) dut_pp (
      .clk (clk),
      .rst (rst),
      .bus (pp_if)
   );

   function automatic logic [3:0] unmask(input logic [W-1:0] sh);
      logic [3:0] acc;
      acc = '0;
      for (int s = 0; s < SHARES; s++) acc ^= sh[s*WIDTH +: WIDTH];
      return acc;
   endfunction

   function automatic logic [W-1:0] mask_shares(input logic [3:0] v);
      logic [W-1:0] r;
      logic [3:0]   acc;
      acc = v;
      r   = '0;
      for (int s = 1; s < SHARES; s++) begin
         r[s*WIDTH +: WIDTH] = 4'($urandom_range(0, 15));
         acc ^= r[s*WIDTH +: WIDTH];
      end
      r[WIDTH-1:0] = acc;
      return r;
   endfunction

   // Expected result for input shares sh carrying value v: share 0 re-masked to S(v).
   function automatic logic [W-1:0] expect_shares(input logic [W-1:0] sh, input logic [3:0] v);
      logic [W-1:0] r;
      r = sh;
      r[WIDTH-1:0] = sh[WIDTH-1:0] ^ v ^ SBOX_TAB[v];
      return r;
   endfunction

   // Combinational part of the reference core.
   function automatic logic [W-1:0] core_f(input logic [W-1:0] sh);
      logic [W-1:0] r;
      logic [3:0]   x;
      x = unmask(sh);
      r = sh;
      r[WIDTH-1:0] = sh[WIDTH-1:0] ^ x ^ SBOX_TAB[x];
      return r;
   endfunction

   // Reference cores: LAT enabled register stages.
   logic [W-1:0] it_st [LAT];
   logic [W-1:0] pp_st [LAT];

   always @(posedge clk) begin
      if (it_if.core_en) begin
         for (int k = LAT - 1; k > 0; k--) it_st[k] <= it_st[k-1];
         it_st[0] <= core_f(it_if.core_in);
      end
   end

   always @(posedge clk) begin
      if (pp_if.core_en) begin
         for (int k = LAT - 1; k > 0; k--) pp_st[k] <= pp_st[k-1];
         pp_st[0] <= core_f(pp_if.core_in);
      end
   end

   assign it_if.core_out = it_st[LAT-1];
   assign pp_if.core_out = pp_st[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Scoreboard monitor: pops on every completed output transfer.
   always @(negedge clk) begin
      if (rst) begin
         if (it_if.out_valid && it_if.out_ready) begin
            if (it_q.size() == 0) check("it_unexpected_result", 1, 0);
            else                  check("it_result", it_if.out_shares, it_q.pop_front());
         end
         if (pp_if.out_valid && pp_if.out_ready) begin
            if (pp_q.size() == 0) check("pp_unexpected_result", 1, 0);
            else                  check("pp_result", pp_if.out_shares, pp_q.pop_front());
         end
         if (it_if.Synch)     it_synch_n++;
         if (pp_if.out_valid) pp_log.push_back(cyc);
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_outputs_zero(input string tag);
      check($sformatf("%s_in_ready", tag),   {it_if.in_ready, pp_if.in_ready}, 0);
      check($sformatf("%s_core_en", tag),    {it_if.core_en, pp_if.core_en, it_if.rnd_req, pp_if.rnd_req}, 0);
      check($sformatf("%s_out_valid", tag),  {it_if.out_valid, pp_if.out_valid}, 0);
      check($sformatf("%s_synch", tag),      {it_if.Synch, pp_if.Synch}, 0);
      check($sformatf("%s_busy", tag),       {it_if.busy, pp_if.busy}, 0);
      check($sformatf("%s_core_in", tag),    it_if.core_in | pp_if.core_in, 0);
      check($sformatf("%s_out_shares", tag), it_if.out_shares | pp_if.out_shares, 0);
   endtask

   // Present v to the iterative instance, wait (bounded) for in_ready, pass the accept edge.
   task automatic it_accept(input logic [3:0] v);
      logic [W-1:0] sh;
      int           n;
      sh = mask_shares(v);
      it_if.in_shares = sh;
      it_if.in_valid  = 1'b1;
      n = 0;
      while (!it_if.in_ready && n < 40) begin
         step();
         n++;
      end
      check("it_accept_ready", it_if.in_ready, 1);
      it_q.push_back(expect_shares(sh, v));
      step();
      it_if.in_valid = 1'b0;
   endtask

   // One iterative operation; rnd_valid dropped for cycles [drop_at, drop_at+drops).
   task automatic it_op(input string tag, input logic [3:0] v, input logic [3:0] exp_u,
                        input int drop_at, input int drops, input int exp_lat);
      int lat;
      int en_cnt;
      bit rdy_seen;
      it_if.out_ready = 1'b1;
      it_accept(v);
      lat      = 1;
      en_cnt   = 0;
      rdy_seen = 1'b0;
      while (lat < 40) begin
         it_if.rnd_valid = !(lat >= drop_at && lat < drop_at + drops);
         @(negedge clk);
         if (it_if.out_valid) break;
         if (it_if.rnd_req)  en_cnt++;
         if (it_if.in_ready) rdy_seen = 1'b1;
         step();
         lat++;
      end
      it_if.rnd_valid = 1'b1;
      check($sformatf("%s_latency", tag),  lat, exp_lat);
      check($sformatf("%s_rnd_req", tag),  en_cnt, LAT);
      check($sformatf("%s_rdy_low", tag),  rdy_seen, 0);
      check($sformatf("%s_synch", tag),    it_if.Synch, 1);
      check($sformatf("%s_unmasked", tag), unmask(it_if.out_shares), exp_u);
      step();
      @(negedge clk);
      check($sformatf("%s_drained", tag), {it_if.out_valid, it_if.Synch}, 0);
      step();
   endtask

   // Pipelined random traffic against a small occupancy model; last n_drain cycles drain.
   task automatic pp_rand(input int n_rand, input int n_drain);
      logic [LAT:0] sv;
      bit           ov_m;
      bit           stall_m;
      bit           drain;
      logic [3:0]   v;
      logic [W-1:0] sh;
      sv   = '0;
      ov_m = 1'b0;
      for (int c = 0; c < n_rand + n_drain; c++) begin
         drain = (c >= n_rand);
         v  = 4'($urandom_range(0, 15));
         sh = mask_shares(v);
         pp_if.in_shares = sh;
         pp_if.in_valid  = drain ? 1'b0 : 1'($urandom_range(0, 1));
         pp_if.out_ready = drain ? 1'b1 : ($urandom_range(0, 2) != 0);
         pp_if.rnd_valid = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
         @(negedge clk);
         stall_m = (ov_m && !pp_if.out_ready && sv[LAT]) || !pp_if.rnd_valid;
         check("pp_in_ready", pp_if.in_ready, !stall_m);
         check("pp_core_en", pp_if.core_en, !stall_m);
         check("pp_out_valid", pp_if.out_valid, ov_m);
         if (pp_if.in_valid && !stall_m) pp_q.push_back(expect_shares(sh, v));
         if (!stall_m && sv[LAT]) ov_m = 1'b1;
         else if (pp_if.out_ready) ov_m = 1'b0;
         if (!stall_m) sv = {sv[LAT-1:0], pp_if.in_valid};
         step();
      end
   endtask

   initial begin
      logic [W-1:0] sh;
      int           t0;
      int           n;
      bit           seen;

      rst = 1'b0;
      it_if.in_valid = 1'b0;  it_if.in_shares = '0;  it_if.rnd_valid = 1'b1;  it_if.out_ready = 1'b1;
      pp_if.in_valid = 1'b0;  pp_if.in_shares = '0;  pp_if.rnd_valid = 1'b1;  pp_if.out_ready = 1'b1;

      // Reset state, then in_ready comes up one edge after release.
      repeat (3) step();
      @(negedge clk);
      check_outputs_zero("reset");
      step();
      rst = 1'b1;
      step();
      @(negedge clk);
      check("release_in_ready", {it_if.in_ready, pp_if.in_ready}, 2'b11);
      step();

      // Iterative: nominal latency, then latency with three randomness gaps.
      it_op("it_zero", 4'h0, 4'hC, 0, 0, 12);
      check("it_synch_once", it_synch_n, 1);
      it_op("it_rnd_gap", 4'h5, 4'hA, 3, 3, 15);

      // Iterative back-pressure: result A held, B waits in CAP, then load and drain together.
      it_if.out_ready = 1'b0;
      it_accept(4'h9);
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = it_if.out_valid;
         step();
      end
      check("it_hold_first_valid", seen, 1);
      it_accept(4'hA);
      repeat (LAT) step();
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("it_cap_core_en", it_if.core_en, 0);
         check("it_cap_in_ready", it_if.in_ready, 0);
         check("it_cap_busy", it_if.busy, 1);
         check("it_cap_held", {it_if.out_valid, unmask(it_if.out_shares)}, {1'b1, 4'h8});
         step();
      end
      it_if.out_ready = 1'b1;
      step();
      @(negedge clk);
      check("it_swap_valid_synch", {it_if.out_valid, it_if.Synch}, 2'b11);
      check("it_swap_in_ready", it_if.in_ready, 1);
      check("it_swap_unmasked", unmask(it_if.out_shares), 4'h5);
      step();
      step();
      check("it_sb_empty", it_q.size(), 0);

      // Pipelined: 16 back-to-back inputs give 16 consecutive results.
      pp_log.delete();
      t0 = 0;
      for (int i = 0; i < 16; i++) begin
         sh = mask_shares(4'(i));
         pp_if.in_shares = sh;
         pp_if.in_valid  = 1'b1;
         @(negedge clk);
         if (i == 0) t0 = cyc;
         check("pp_b2b_in_ready", pp_if.in_ready, 1);
         pp_q.push_back(expect_shares(sh, 4'(i)));
         step();
      end
      pp_if.in_valid = 1'b0;
      repeat (20) step();
      n = pp_log.size();
      check("pp_b2b_count", n, 16);
      check("pp_b2b_first", (n > 0) ? pp_log[0] - t0 : -1, 12);
      check("pp_b2b_contiguous", (n > 0) ? pp_log[n-1] - pp_log[0] : -1, 15);
      check("pp_b2b_sb_empty", pp_q.size(), 0);
      check("pp_idle_busy", pp_if.busy, 0);

      // Pipelined random back-pressure and randomness starvation.
      pp_rand(300, 30);
      check("pp_rand_sb_empty", pp_q.size(), 0);
      check("pp_rand_busy", pp_if.busy, 0);
      pp_if.in_valid = 1'b0;

      // Reset mid-RUN and mid-pipe.
      it_accept(4'h3);
      for (int i = 0; i < 5; i++) begin
         pp_if.in_shares = mask_shares(4'(i));
         pp_if.in_valid  = 1'b1;
         step();
      end
      pp_if.in_valid = 1'b0;
      rst = 1'b0;
      #1;
      check_outputs_zero("mid_reset");
      it_q.delete();
      pp_q.delete();
      step();
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (it_if.out_valid || pp_if.out_valid || it_if.Synch || pp_if.Synch) seen = 1'b1;
         step();
      end
      check("post_reset_no_stale", seen, 0);
      check("post_reset_in_ready", {it_if.in_ready, pp_if.in_ready}, 2'b11);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

endmodule
